// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, with valid/ready handshakes.
module alu_mc #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_acc;       // running high product / partial remainder
    logic [WIDTH-1:0]  r_q;         // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]  r_b;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]  r_a;         // original dividend for divide-by-zero
    logic              r_is_div;
    logic              r_neg_lo;
    logic              r_neg_hi;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  r_hi;
    logic              r_zero;
    logic              r_dbz;

    state_t            w_state_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [WIDTH-1:0]  w_acc_nx;
    logic [WIDTH-1:0]  w_q_nx;
    logic [WIDTH-1:0]  w_b_nx;
    logic [WIDTH-1:0]  w_a_nx;
    logic              w_is_div_nx;
    logic              w_neg_lo_nx;
    logic              w_neg_hi_nx;
    logic [WIDTH-1:0]  w_result_nx;
    logic [WIDTH-1:0]  w_hi_nx;
    logic              w_dbz_nx;

    logic              w_accept;
    logic              w_is_md;
    logic              w_sa;
    logic              w_sb;
    logic [WIDTH-1:0]  w_ma;
    logic [WIDTH-1:0]  w_mb;
    logic [WIDTH-1:0]  w_alu;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH:0]    w_div_sh;
    logic              w_div_ge;
    logic [WIDTH-1:0]  w_div_diff;
    logic [WIDTH-1:0]  w_step_acc;
    logic [WIDTH-1:0]  w_step_q;
    logic [PW-1:0]     w_prod;
    logic [WIDTH-1:0]  w_fin_lo;
    logic [WIDTH-1:0]  w_fin_hi;
    logic              w_fin_dbz;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign hi          = r_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

    assign w_accept = in_valid && r_in_ready;
    assign w_is_md  = MULDIV_EN && (alucont[3:2] == 2'b10);

    // Operand signs and magnitudes; bit 0 of the mul/div opcode selects signed
    always_comb begin
        w_sa = alucont[0] & a[WIDTH-1];
        w_sb = alucont[0] & b[WIDTH-1];
        w_ma = w_sa ? (-a) : a;
        w_mb = w_sb ? (-b) : b;
    end

    // Single-cycle operations; anything unlisted yields zero
    always_comb begin
        w_alu = '0;
        case (alucont)
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_ADD:  w_alu = a + b;
            OP_XOR:  w_alu = a ^ b;
            OP_NOR:  w_alu = ~(a | b);
            OP_SUB:  w_alu = a - b;
            OP_SLT:  w_alu = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: w_alu = WIDTH'(a < b);
            default: w_alu = '0;
        endcase
    end

    // One multiply or divide iteration plus sign/exception fix-up of the final step
    always_comb begin
        w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_div_sh   = {r_acc, r_q[WIDTH-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_b});
        w_div_diff = w_div_sh[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_step_acc = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            w_step_q   = {r_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_acc = w_mul_sum[WIDTH:1];
            w_step_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
        w_prod    = {w_step_acc, w_step_q};
        w_fin_dbz = 1'b0;
        if (r_is_div) begin
            if (r_b == '0) begin
                w_fin_lo  = '1;
                w_fin_hi  = r_a;
                w_fin_dbz = 1'b1;
            end else begin
                w_fin_lo = r_neg_lo ? (-w_step_q) : w_step_q;
                w_fin_hi = r_neg_hi ? (-w_step_acc) : w_step_acc;
            end
        end else begin
            if (r_neg_lo) begin
                w_prod = -w_prod;
            end
            w_fin_lo = w_prod[WIDTH-1:0];
            w_fin_hi = w_prod[PW-1:WIDTH];
        end
    end

    // Next-state and next-register values for control and datapath
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_acc_nx    = r_acc;
        w_q_nx      = r_q;
        w_b_nx      = r_b;
        w_a_nx      = r_a;
        w_is_div_nx = r_is_div;
        w_neg_lo_nx = r_neg_lo;
        w_neg_hi_nx = r_neg_hi;
        w_result_nx = r_result;
        w_hi_nx     = r_hi;
        w_dbz_nx    = r_dbz;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_md) begin
                        w_state_nx  = S_CALC;
                        w_cnt_nx    = CW'(WIDTH - 1);
                        w_acc_nx    = '0;
                        w_is_div_nx = alucont[1];
                        w_q_nx      = alucont[1] ? w_ma : w_mb;
                        w_b_nx      = alucont[1] ? w_mb : w_ma;
                        w_a_nx      = a;
                        w_neg_lo_nx = w_sa ^ w_sb;
                        w_neg_hi_nx = alucont[1] ? w_sa : (w_sa ^ w_sb);
                    end else begin
                        w_state_nx  = S_DONE;
                        w_result_nx = w_alu;
                        w_hi_nx     = '0;
                        w_dbz_nx    = 1'b0;
                    end
                end
            end
            S_CALC: begin
                w_acc_nx = w_step_acc;
                w_q_nx   = w_step_q;
                w_cnt_nx = r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    w_state_nx  = S_DONE;
                    w_result_nx = w_fin_lo;
                    w_hi_nx     = w_fin_hi;
                    w_dbz_nx    = w_fin_dbz;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_a         <= '0;
            r_is_div    <= 1'b0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zero      <= 1'b1;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_acc       <= w_acc_nx;
            r_q         <= w_q_nx;
            r_b         <= w_b_nx;
            r_a         <= w_a_nx;
            r_is_div    <= w_is_div_nx;
            r_neg_lo    <= w_neg_lo_nx;
            r_neg_hi    <= w_neg_hi_nx;
            r_in_ready  <= (w_state_nx == S_IDLE);
            r_out_valid <= (w_state_nx == S_DONE);
            r_result    <= w_result_nx;
            r_hi        <= w_hi_nx;
            r_zero      <= (w_result_nx == '0);
            r_dbz       <= w_dbz_nx;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32 with hand-computed results.
module tb_alu_mc;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alucont;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_mis = 0;

    alu_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alucont    (alucont),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .hi         (hi),
        .zero       (zero),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one request, hold it until the accepting edge, then scramble inputs
    task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a        = av;
        b        = bv;
        alucont  = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alucont  = 4'($urandom);
    endtask

    // Full transaction: latency, in_ready low while busy, result fields, hold, retire
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic ez, input logic edbz, input int elat, input int hold);
        int lat;
        bit rdy_seen;
        issue(tag, op, av, bv);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
        check_eq({tag, "_latency"}, 64'(lat), 64'(elat));
        check_eq({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
        check_eq({tag, "_result"}, 64'(result), 64'(er));
        check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "_zero"}, 64'(zero), 64'(ez));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, "_hold_result"}, 64'(result), 64'(er));
            check_eq({tag, "_hold_hi"}, 64'(hi), 64'(eh));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_retired_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_retired_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit stale;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alucont   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd1);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle operations
        run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("sltu", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("xor", 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("nor", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("undef", 4'b0101, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);

        // Multiply
        run_op("mul_neg", 4'b1001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
        run_op("mul_negneg", 4'b1001, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6, 32'h0, 1'b0, 1'b0, 33, 0);
        run_op("mulu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
        run_op("mulu_lozero", 4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b1, 1'b0, 33, 0);

        // Divide
        run_op("div_neg", 4'b1011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
        run_op("div_negdivisor", 4'b1011, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33, 0);
        run_op("divu_by0", 4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1, 33, 0);
        run_op("div_by0", 4'b1011, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1, 33, 0);
        run_op("div_ovf", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 33, 0);
        run_op("divu_hold", 4'b1010, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 10);

        // Reset in the middle of a multiply
        issue("mulu_abort", 4'b1000, 32'd12345, 32'd678);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("abort_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check_eq("abort_no_stale", 64'(stale), 64'd0);

        // Block still works after the abort
        run_op("mulu_after", 4'b1000, 32'd12345, 32'd678, 32'd8369910, 32'h0, 1'b0, 1'b0, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
